// File: rtl/m_serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
// The master drives a request, the slave returns status and result.
interface m_serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             w_start;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic             w_cin;
   logic             w_busy;
   logic             w_done;
   logic [WIDTH-1:0] w_s;
   logic             w_cout;

   modport master (
      output w_start, w_a, w_b, w_cin,
      input  w_busy, w_done, w_s, w_cout
   );

   modport slave (
      input  w_start, w_a, w_b, w_cin,
      output w_busy, w_done, w_s, w_cout
   );
endinterface

// File: rtl/m_serial_adder.sv
// Bit-serial adder: one full adder, LSB first, WIDTH cycles per op.
// Carry is held in a flip-flop between bit slices.
module m_FA (
   input  logic w_a,
   input  logic w_b,
   input  logic w_cin,
   output logic w_s,
   output logic w_cout
);
   assign w_s    = w_a ^ w_b ^ w_cin;
   assign w_cout = (w_a & w_b) | (w_cin & (w_a ^ w_b));
endmodule

module m_serial_adder #(
   parameter int WIDTH = 8
) (
   input logic w_clk,
   input logic w_rst_n,
   m_serial_adder_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_c;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] r_s;
   logic [WIDTH-1:0] s_nxt;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
   logic             fa_s;
   logic             fa_co;

   m_FA u_fa (
      .w_a   (r_a[0]),
      .w_b   (r_b[0]),
      .w_cin (r_c),
      .w_s   (fa_s),
      .w_cout(fa_co)
   );

   // New sum bit enters at the MSB; the register shifts right.
   generate
      if (WIDTH == 1) begin : g_s1
         assign s_nxt = fa_s;
      end else begin : g_sn
         assign s_nxt = {fa_s, r_s[WIDTH-1:1]};
      end
   endgenerate

   // Sequencer: capture, WIDTH bit slices, one-cycle done.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state  <= IDLE;
         r_a    <= '0;
         r_b    <= '0;
         r_c    <= 1'b0;
         cnt    <= '0;
         r_s    <= '0;
         r_cout <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.w_start) begin
                  r_a    <= bus.w_a;
                  r_b    <= bus.w_b;
                  r_c    <= bus.w_cin;
                  cnt    <= '0;
                  r_s    <= '0;
                  r_cout <= 1'b0;
                  r_busy <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               r_a <= r_a >> 1;
               r_b <= r_b >> 1;
               r_s <= s_nxt;
               r_c <= fa_co;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  r_cout <= fa_co;
                  r_done <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               r_done <= 1'b0;
               r_busy <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.w_busy = r_busy;
   assign bus.w_done = r_done;
   assign bus.w_s    = r_s;
   assign bus.w_cout = r_cout;
endmodule

// File: tb/tb_m_serial_adder.sv
// Bench for m_serial_adder: WIDTH=8 and WIDTH=1 instances
// checked every cycle against an arithmetic model.
module tb_m_serial_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       st [2];
   logic [7:0] ta [2];
   logic [7:0] tb_b [2];
   logic       tc [2];
   logic       ob [2];
   logic       od [2];
   logic [7:0] os [2];
   logic       oc [2];
   int         wd [2];

   m_serial_adder_if #(.WIDTH(8)) i8 ();
   m_serial_adder_if #(.WIDTH(1)) i1 ();

   m_serial_adder #(.WIDTH(8)) dut8 (
      .w_clk  (clk),
      .w_rst_n(rst_n),
      .bus    (i8.slave)
   );
   m_serial_adder #(.WIDTH(1)) dut1 (
      .w_clk  (clk),
      .w_rst_n(rst_n),
      .bus    (i1.slave)
   );

   assign i8.w_start = st[0];
   assign i8.w_a     = ta[0];
   assign i8.w_b     = tb_b[0];
   assign i8.w_cin   = tc[0];
   assign i1.w_start = st[1];
   assign i1.w_a     = ta[1][0:0];
   assign i1.w_b     = tb_b[1][0:0];
   assign i1.w_cin   = tc[1];
   assign ob[0] = i8.w_busy;
   assign od[0] = i8.w_done;
   assign os[0] = i8.w_s;
   assign oc[0] = i8.w_cout;
   assign ob[1] = i1.w_busy;
   assign od[1] = i1.w_done;
   assign os[1] = {7'd0, i1.w_s};
   assign oc[1] = i1.w_cout;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: cycles since acceptance, and the result that must show
   // once the op has finished.
   int ph [2];
   int ex [2];
   int hs [2];
   int hc [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            ph[i] <= -1;
            hs[i] <= 0;
            hc[i] <= 0;
            ex[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (ph[i] < 0) begin
               if (st[i]) begin
                  ph[i] <= 0;
                  ex[i] <= (int'(ta[i]) & ((1 << wd[i]) - 1))
                         + (int'(tb_b[i]) & ((1 << wd[i]) - 1))
                         + int'(tc[i]);
                  hs[i] <= 0;
                  hc[i] <= 0;
               end
            end else begin
               if (ph[i] + 1 == wd[i]) begin
                  hs[i] <= ex[i] & ((1 << wd[i]) - 1);
                  hc[i] <= (ex[i] >> wd[i]) & 1;
               end
               ph[i] <= (ph[i] == wd[i]) ? -1 : ph[i] + 1;
            end
         end
      end
   end

   // Every-cycle compare; sum is only meaningful when not mid-op.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("w%0d_busy", wd[i]), 32'(ob[i]), 32'(ph[i] >= 0));
         chk($sformatf("w%0d_done", wd[i]), 32'(od[i]), 32'(ph[i] == wd[i]));
         if (ph[i] < 0 || ph[i] == wd[i]) begin
            chk($sformatf("w%0d_s", wd[i]), 32'(os[i]), 32'(hs[i]));
            chk($sformatf("w%0d_cout", wd[i]), 32'(oc[i]), 32'(hc[i]));
         end
      end
   end

   task automatic start8(logic [7:0] a, logic [7:0] b, logic c);
      @(posedge clk); #1;
      st[0] = 1'b1; ta[0] = a; tb_b[0] = b; tc[0] = c;
      @(posedge clk); #1;
      st[0] = 1'b0;
   endtask

   task automatic wait_done(int idx, string nm);
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (od[idx]) seen = 1;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no done want done", nm);
      end
   endtask

   task automatic op8(string nm, logic [7:0] a, logic [7:0] b, logic c,
                      logic [7:0] s, logic co);
      start8(a, b, c);
      wait_done(0, nm);
      chk({nm, "_s"}, 32'(os[0]), 32'(s));
      chk({nm, "_cout"}, 32'(oc[0]), 32'(co));
   endtask

   initial begin
      int t1;
      int t2;
      wd[0] = 8;
      wd[1] = 1;
      for (int i = 0; i < 2; i++) begin
         st[i] = 0; ta[i] = 0; tb_b[i] = 0; tc[i] = 0;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(ob[0]), 0);
      chk("rst_s", 32'(os[0]), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      op8("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      op8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      op8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

      // Request while busy must be ignored.
      start8(8'h01, 8'h01, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      st[0] = 1'b1; ta[0] = 8'hF0;
      @(posedge clk); #1;
      st[0] = 1'b0;
      wait_done(0, "t3");
      chk("t3_s", 32'(os[0]), 32'h02);
      repeat (3) @(negedge clk);

      // Async reset mid-op.
      start8(8'h77, 8'h11, 1'b1);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_busy", 32'(ob[0]), 0);
      chk("t4_done", 32'(od[0]), 0);
      chk("t4_s", 32'(os[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      op8("t4_after", 8'h77, 8'h11, 1'b1, 8'h89, 1'b0);

      // Start held high: back-to-back ops.
      t1 = -1;
      t2 = -1;
      @(posedge clk); #1;
      st[0] = 1'b1;
      for (int k = 0; k < 30; k++) begin
         ta[0] = 8'($urandom);
         tb_b[0] = 8'($urandom);
         tc[0] = 1'($urandom);
         @(negedge clk);
         if (od[0]) begin
            if (t1 < 0) t1 = cyc;
            else if (t2 < 0) t2 = cyc;
         end
         @(posedge clk); #1;
      end
      st[0] = 1'b0;
      chk("t5_gap", 32'(t2 - t1), 32'd10);
      repeat (12) @(negedge clk);

      // WIDTH=1: all eight input combinations.
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         st[1] = 1'b1;
         ta[1] = 8'(k & 1);
         tb_b[1] = 8'((k >> 1) & 1);
         tc[1] = 1'((k >> 2) & 1);
         @(posedge clk); #1;
         st[1] = 1'b0;
         wait_done(1, "w1");
         chk("w1_lit_s", 32'(os[1]), 32'((k ^ (k >> 1) ^ (k >> 2)) & 1));
         chk("w1_lit_c", 32'(oc[1]), 32'(k == 3 || k >= 5));
      end

      // Random sweep on both widths.
      for (int k = 0; k < 12000; k++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            st[i] = 1'($urandom);
            ta[i] = 8'($urandom);
            tb_b[i] = 8'($urandom);
            tc[i] = 1'($urandom);
         end
      end
      st[0] = 0;
      st[1] = 0;
      repeat (15) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
